wb_port_arbiter: RTL and testbench

- Owns the single register-file write port of the multicycle core and drives the 3-bit select of the write-data source mux (DataSrc_control).
- Eight producers post one-cycle write requests with a destination register, for example ALU result, memory load, HI, LO, shifter, LUI and link PC.
- The block queues one pending write per producer and grants them one per cycle, round-robin.
- Select, write enable and write address are all driven from registers.

---
 rtl/wb_port_arbiter_pkg.sv | 23 ++
 rtl/wb_port_arbiter_if.sv | 39 +++
 rtl/wb_port_arbiter_rr_pick8.sv | 22 ++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: source indices in
// write-data mux order, FSM state type and register-file geometry.
package wb_pkg;

  localparam int REG_N  = 32;
  localparam int REG_AW = $clog2(REG_N);

  localparam logic [2:0] SRC_ALU   = 3'd0;
  localparam logic [2:0] SRC_MEM   = 3'd1;
  localparam logic [2:0] SRC_HI    = 3'd2;
  localparam logic [2:0] SRC_LO    = 3'd3;
  localparam logic [2:0] SRC_SHIFT = 3'd4;
  localparam logic [2:0] SRC_LUI   = 3'd5;
  localparam logic [2:0] SRC_LINK  = 3'd6;
  localparam logic [2:0] SRC_AUX   = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    STALL = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the eight write-back producers and the register-file
// write-port arbiter. Optional macro WB_SCOREBOARD_EN adds reg_busy.
interface wb_port_arbiter_if #(
  parameter int NUM_SRC = 8,
  parameter int REG_N   = 32,
  parameter int REG_AW  = $clog2(REG_N)
);
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*REG_AW-1:0] req_dst;
  logic                      wb_stall;
  logic                      flush;
  logic [NUM_SRC-1:0]        ack;
  logic [2:0]                DataSrc_control;
  logic                      RegWrite;
  logic [REG_AW-1:0]         WriteReg;
  logic                      busy;
  logic                      overflow_err;
`ifdef WB_SCOREBOARD_EN
  logic [REG_N-1:0]          reg_busy;
`endif

  // Producer / decoder side.
  modport master (
    output req, req_dst, wb_stall, flush,
    input  ack, DataSrc_control, RegWrite, WriteReg, busy, overflow_err
`ifdef WB_SCOREBOARD_EN
    , input reg_busy
`endif
  );

  // Arbiter side.
  modport slave (
    input  req, req_dst, wb_stall, flush,
    output ack, DataSrc_control, RegWrite, WriteReg, busy, overflow_err
`ifdef WB_SCOREBOARD_EN
    , output reg_busy
`endif
  );
endinterface

// File: rtl/wb_port_arbiter_rr_pick8.sv
// Combinational round-robin picker over eight request bits: returns the
// first set bit at or after the pointer, wrapping 7->0.
module rr_pick8 (
  input  logic [7:0] i_pending,
  input  logic [2:0] i_ptr,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int off = 7; off >= 0; off--) begin
      if (i_pending[i_ptr + 3'(off)]) begin
        o_idx   = i_ptr + 3'(off);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: one pending write per producer, one
// registered grant per cycle, round-robin. Optional macro WB_SCOREBOARD_EN
// exposes a per-register in-flight map (reg_busy).
module wb_port_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int REG_N   = wb_pkg::REG_N,
  parameter int REG_AW  = $clog2(REG_N)
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_port_arbiter_if.slave   bus
);
  import wb_pkg::*;

  wb_state_e          r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_pending, r_ack;
  logic [NUM_SRC-1:0] w_live, w_accept, w_eff, w_grant_oh;
  logic [REG_AW-1:0]  r_dst     [NUM_SRC];
  logic [REG_AW-1:0]  w_dst_nxt [NUM_SRC];
  logic [2:0]         r_ptr, r_sel, w_idx;
  logic [REG_AW-1:0]  r_wreg;
  logic               r_regwrite, r_ovf;
  logic               w_valid, w_grant, w_ovf_hit;

  // A pending entry that is not being acked this cycle is still waiting;
  // the acked one retires at this edge, so its slot is free again.
  assign w_live     = r_pending & ~r_ack;
  assign w_accept   = bus.req & ~w_live & {NUM_SRC{~bus.flush}};
  assign w_eff      = w_live | w_accept;
  assign w_ovf_hit  = |(bus.req & w_live);

  rr_pick8 u_pick (
    .i_pending (w_eff),
    .i_ptr     (r_ptr),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  assign w_grant    = w_valid & ~bus.wb_stall & ~bus.flush;
  assign w_grant_oh = w_grant ? (NUM_SRC'(1) << w_idx) : '0;

  // Destination seen by the arbiter: fresh capture overrides the latch.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dst_nxt[i] = w_accept[i] ? bus.req_dst[i*REG_AW +: REG_AW] : r_dst[i];
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_eff) w_state_nxt = bus.wb_stall ? STALL : ARB;
      ARB:     if (bus.wb_stall) w_state_nxt = STALL;
               else if (w_eff == '0) w_state_nxt = IDLE;
      STALL:   if (!bus.wb_stall) w_state_nxt = ARB;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.flush) w_state_nxt = IDLE;
  end

  // State, pending set, pointer and the registered write-port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_ack      <= '0;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_wreg     <= '0;
      r_regwrite <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= bus.flush ? '0 : w_eff;
      r_ack      <= w_grant_oh;
      r_regwrite <= w_grant && (w_dst_nxt[w_idx] != '0);
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_grant) begin
        r_sel  <= w_idx;
        r_wreg <= w_dst_nxt[w_idx];
        r_ptr  <= w_idx + 3'd1;
      end
    end
  end

  // Destination latches, loaded only when a request is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SRC; i++) r_dst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) r_dst[i] <= w_dst_nxt[i];
    end
  end

  assign bus.ack             = r_ack;
  assign bus.DataSrc_control = r_sel;
  assign bus.RegWrite        = r_regwrite;
  assign bus.WriteReg        = r_wreg;
  assign bus.busy            = |r_pending;
  assign bus.overflow_err    = r_ovf;

`ifdef WB_SCOREBOARD_EN
  logic [REG_N-1:0] w_reg_busy;

  // In-flight register map from the pending set; $zero is never busy.
  always_comb begin
    w_reg_busy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_pending[i]) w_reg_busy[r_dst[i]] = 1'b1;
    end
    w_reg_busy[0] = 1'b0;
  end

  assign bus.reg_busy = w_reg_busy;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a set-based reference model.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int NS = 8;
  localparam int RN = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_SRC(NS), .REG_N(RN), .REG_AW(AW)) bus ();

  wb_port_arbiter #(.NUM_SRC(NS), .REG_N(RN), .REG_AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: set of waiting writes, their destinations, the
  // currently presented grant and the round-robin start position.
  bit m_wait [NS];
  int m_dst  [NS];
  int m_ptr, m_ack, m_sel, m_wreg;
  bit m_rw, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_wait[i] = 1'b0;
      m_dst[i]  = 0;
    end
    m_ptr = 0; m_ack = -1; m_sel = 0; m_wreg = 0; m_rw = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [NS-1:0] rq, input logic [NS*AW-1:0] rd,
                            input logic st, input logic fl);
    for (int i = 0; i < NS; i++) begin
      if (rq[i]) begin
        if (m_wait[i]) m_ovf = 1'b1;
        else if (!fl) begin
          m_wait[i] = 1'b1;
          m_dst[i]  = int'(rd[i*AW +: AW]);
        end
      end
    end
    m_ack = -1;
    if (fl) begin
      for (int i = 0; i < NS; i++) m_wait[i] = 1'b0;
    end else if (!st) begin
      for (int off = 0; off < NS; off++) begin
        int k;
        k = (m_ptr + off) % NS;
        if (m_wait[k] && m_ack < 0) begin
          m_wait[k] = 1'b0;
          m_ack  = k;
          m_sel  = k;
          m_wreg = m_dst[k];
          m_rw   = (m_dst[k] != 0);
          m_ptr  = (k + 1) % NS;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NS-1:0] e_ack;
    bit e_busy;
    e_ack  = (m_ack >= 0) ? (NS'(1) << m_ack) : '0;
    e_busy = (m_ack >= 0);
    for (int i = 0; i < NS; i++) if (m_wait[i]) e_busy = 1'b1;
    chk("ack",      32'(bus.ack),             32'(e_ack));
    chk("datasrc",  32'(bus.DataSrc_control), 32'(m_sel));
    chk("regwrite", 32'(bus.RegWrite),        32'((m_ack >= 0) && m_rw));
    chk("writereg", 32'(bus.WriteReg),        32'(m_wreg));
    chk("busy",     32'(bus.busy),            32'(e_busy));
    chk("overflow", 32'(bus.overflow_err),    32'(m_ovf));
`ifdef WB_SCOREBOARD_EN
    begin
      logic [RN-1:0] e_rb;
      e_rb = '0;
      for (int i = 0; i < NS; i++) if (m_wait[i] || m_ack == i) e_rb[m_dst[i]] = 1'b1;
      e_rb[0] = 1'b0;
      chk("reg_busy", bus.reg_busy, e_rb);
    end
`endif
  endtask

  // One clock: apply inputs, advance model at the edge, compare mid-cycle.
  task automatic step(input logic [NS-1:0] rq, input logic [NS*AW-1:0] rd,
                      input logic st, input logic fl);
    bus.req = rq; bus.req_dst = rd; bus.wb_stall = st; bus.flush = fl;
    @(posedge clk);
    model_step(rq, rd, st, fl);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [NS*AW-1:0] put(input logic [NS*AW-1:0] v, input int i, input int d);
    v[i*AW +: AW] = AW'(d);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NS*AW-1:0] d;
    reset_n = 1'b0;
    bus.req = '0; bus.req_dst = '0; bus.wb_stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Single request from the memory path to r9.
    d = put('0, int'(SRC_MEM), 9);
    step(NS'(1) << SRC_MEM, d, 1'b0, 1'b0);
    idle(2);

    // All eight producers at once, destinations 1..8.
    d = '0;
    for (int i = 0; i < NS; i++) d = put(d, i, i + 1);
    step('1, d, 1'b0, 1'b0);
    idle(9);

    // Fairness: ALU re-posts in each of its grant cycles while LO waits.
    d = put(put('0, int'(SRC_ALU), 11), int'(SRC_LO), 12);
    step(8'b0000_1001, d, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(bus.ack[SRC_ALU] ? 8'b0000_0001 : 8'b0, put('0, int'(SRC_ALU), 13 + c), 1'b0, 1'b0);
    end
    idle(3);

    // $zero destination from LUI: acked, write suppressed.
    step(NS'(1) << SRC_LUI, put('0, int'(SRC_LUI), 0), 1'b0, 1'b0);
    idle(2);

    // Stall for three cycles with two pending, then release.
    d = put(put('0, 2, 20), 6, 21);
    step(8'b0100_0100, d, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    idle(4);

    // Flush with four pending plus a request arriving in the flush cycle.
    d = put(put(put(put('0, 0, 3), 1, 4), 4, 5), 7, 6);
    step(8'b1001_0011, d, 1'b1, 1'b0);
    step(8'b0000_1000, put('0, 3, 7), 1'b0, 1'b1);
    idle(3);

    // Double post from HI before its grant: sticky error, first dst wins.
    step(NS'(1) << SRC_HI, put('0, int'(SRC_HI), 17), 1'b1, 1'b0);
    step(NS'(1) << SRC_HI, put('0, int'(SRC_HI), 18), 1'b1, 1'b0);
    idle(4);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [NS-1:0] rq;
      rq = NS'($urandom) & NS'($urandom);
      d  = '0;
      for (int i = 0; i < NS; i++) d = put(d, i, int'($urandom_range(0, RN - 1)));
      step(rq, d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset in the middle of a burst.
    d = '0;
    for (int i = 0; i < NS; i++) d = put(d, i, 24 + i);
    step('1, d, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
